// File: rtl/tl_pkg.sv
// Shared TileLink helpers: opcode encodings, data-opcode predicate and beat counting.
// Pure types and functions; no timing or flow control of its own.
`timescale 1ns/1ps
package tl_pkg;

   localparam int unsigned TlSizeWidth = 3;

   typedef enum logic [2:0] {
      PutFullData    = 3'd0,
      PutPartialData = 3'd1,
      ArithmeticData = 3'd2,
      LogicalData    = 3'd3,
      Get            = 3'd4,
      Intent         = 3'd5
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'd0,
      AccessAckData = 3'd1,
      HintAck       = 3'd2
   } tl_d_op_e;

   // Only Put* on A and AccessAckData on D span multiple beats here
   function automatic logic tl_has_data(input logic is_d, input logic [2:0] opcode);
      if (is_d) return opcode == AccessAckData;
      return (opcode == PutFullData) || (opcode == PutPartialData);
   endfunction

   // Oversized requests are clamped so the beat counter never runs past its range
   function automatic int unsigned tl_beats(input logic [TlSizeWidth-1:0] size,
                                            input int unsigned lg_beat_bytes,
                                            input int unsigned max_size);
      int unsigned sz;
      sz = 32'(size);
      if (sz > max_size) sz = max_size;
      return (sz > lg_beat_bytes) ? (32'd1 << (sz - lg_beat_bytes)) : 32'd1;
   endfunction

endpackage

// File: rtl/tl_burst_tracker.sv
// Beat tracker for one TL channel: flags first/last beat of the current message.
// Combinational flags from registered count; counts only on fire_i, no backpressure of its own.
`timescale 1ns/1ps
module tl_burst_tracker
   import tl_pkg::*;
#(
   parameter int unsigned DataWidth = 128,
   parameter int unsigned MaxSize   = 6,
   parameter bit          IsD       = 1'b0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   fire_i,
   input  logic [2:0]             opcode_i,
   input  logic [TlSizeWidth-1:0] size_i,
   output logic                   first_o,
   output logic                   last_o
);

   localparam int unsigned LgBeat   = $clog2(DataWidth / 8);
   localparam int unsigned MaxBeats = ((2 ** MaxSize) * 8) / DataWidth;
   localparam int unsigned CntWidth = (MaxBeats > 2) ? $clog2(MaxBeats) : 1;

   logic [CntWidth-1:0] cnt_q;
   logic [CntWidth-1:0] last_cnt;

   always_comb begin
      last_cnt = '0;
      if (tl_has_data(IsD, opcode_i))
         last_cnt = CntWidth'(tl_beats(size_i, LgBeat, MaxSize) - 32'd1);
   end

   assign first_o = (cnt_q == '0);
   assign last_o  = (cnt_q == last_cnt);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt_q <= '0;
      else if (fire_i)
         cnt_q <= last_o ? '0 : cnt_q + 1'b1;
   end

endmodule

// File: rtl/tl_source_remapper.sv
// Maps any host source ID onto a small pool of device IDs for a transaction's lifetime.
// Zero-latency A/D paths; A stalls on a first beat when no slot is free, D is never stalled here.
`timescale 1ns/1ps
module tl_source_remapper
   import tl_pkg::*;
#(
   parameter int unsigned DataWidth         = 128,
   parameter int unsigned AddrWidth         = 56,
   parameter int unsigned SinkWidth         = 1,
   parameter int unsigned HostSourceWidth   = 4,
   parameter int unsigned DeviceSourceWidth = 5,
   parameter int unsigned NumSlots          = 4,
   parameter int unsigned SourceBase        = 0,
   parameter int unsigned MaxSize           = 6
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   // host side
   input  logic                         host_a_valid,
   output logic                         host_a_ready,
   input  logic [2:0]                   host_a_opcode,
   input  logic [2:0]                   host_a_param,
   input  logic [TlSizeWidth-1:0]       host_a_size,
   input  logic [HostSourceWidth-1:0]   host_a_source,
   input  logic [AddrWidth-1:0]         host_a_address,
   input  logic [DataWidth/8-1:0]       host_a_mask,
   input  logic [DataWidth-1:0]         host_a_data,
   input  logic                         host_a_corrupt,
   output logic                         host_d_valid,
   input  logic                         host_d_ready,
   output logic [2:0]                   host_d_opcode,
   output logic [1:0]                   host_d_param,
   output logic [TlSizeWidth-1:0]       host_d_size,
   output logic [HostSourceWidth-1:0]   host_d_source,
   output logic [SinkWidth-1:0]         host_d_sink,
   output logic                         host_d_denied,
   output logic [DataWidth-1:0]         host_d_data,
   output logic                         host_d_corrupt,
   output logic                         host_b_valid,
   output logic                         host_c_ready,
   output logic                         host_e_ready,
   // device side
   output logic                         device_a_valid,
   input  logic                         device_a_ready,
   output logic [2:0]                   device_a_opcode,
   output logic [2:0]                   device_a_param,
   output logic [TlSizeWidth-1:0]       device_a_size,
   output logic [DeviceSourceWidth-1:0] device_a_source,
   output logic [AddrWidth-1:0]         device_a_address,
   output logic [DataWidth/8-1:0]       device_a_mask,
   output logic [DataWidth-1:0]         device_a_data,
   output logic                         device_a_corrupt,
   input  logic                         device_d_valid,
   output logic                         device_d_ready,
   input  logic [2:0]                   device_d_opcode,
   input  logic [1:0]                   device_d_param,
   input  logic [TlSizeWidth-1:0]       device_d_size,
   input  logic [DeviceSourceWidth-1:0] device_d_source,
   input  logic [SinkWidth-1:0]         device_d_sink,
   input  logic                         device_d_denied,
   input  logic [DataWidth-1:0]         device_d_data,
   input  logic                         device_d_corrupt,
   output logic                         device_b_ready,
   output logic                         device_c_valid,
   output logic                         device_e_valid,
   // status
   output logic [$clog2(NumSlots+1)-1:0] outstanding_o,
   output logic                         err_o
);

   localparam int unsigned SlotWidth  = (NumSlots > 1) ? $clog2(NumSlots) : 1;
   localparam int unsigned CountWidth = $clog2(NumSlots + 1);

   if ((NumSlots == 0) || ((NumSlots & (NumSlots - 1)) != 0) || (NumSlots > 2 ** DeviceSourceWidth)) begin : g_slots_chk
      $fatal(1, "NumSlots must be a power of two within the device source space");
   end
   if (((SourceBase % NumSlots) != 0) || (SourceBase + NumSlots > 2 ** DeviceSourceWidth)) begin : g_base_chk
      $fatal(1, "SourceBase must be NumSlots-aligned and fit the device source space");
   end

   typedef struct packed {
      logic                       valid;
      logic [HostSourceWidth-1:0] host_source;
   } slot_t;

   slot_t tbl_q [NumSlots];
   logic [SlotWidth-1:0]  a_slot_q;
   logic                  err_q;

   logic                  any_free, dup_hit, size_err;
   logic [SlotWidth-1:0]  alloc_slot, a_slot, d_slot;
   logic [CountWidth-1:0] occupancy;
   logic                  a_first, a_last, d_first, d_last;
   logic                  a_gate, a_fire, d_fire, d_in_range, d_hit;
   logic [DeviceSourceWidth-1:0] d_off;
   logic                  unused_burst;

   always_comb begin
      any_free   = 1'b0;
      alloc_slot = '0;
      dup_hit    = 1'b0;
      occupancy  = '0;
      // Descending scan leaves the lowest-index free slot as the candidate
      for (int i = NumSlots - 1; i >= 0; i--) begin
         if (!tbl_q[i].valid) begin
            any_free   = 1'b1;
            alloc_slot = SlotWidth'(i);
         end
      end
      for (int i = 0; i < NumSlots; i++) begin
         if (tbl_q[i].valid && (tbl_q[i].host_source == host_a_source)) dup_hit = 1'b1;
         occupancy = occupancy + CountWidth'(tbl_q[i].valid);
      end
   end

   // Mid-burst beats ride the latched slot and never wait for a free one
   assign a_slot         = a_first ? alloc_slot : a_slot_q;
   assign a_gate         = ~rst_i & (~a_first | any_free);
   assign device_a_valid = host_a_valid & a_gate;
   assign host_a_ready   = device_a_ready & a_gate;
   assign a_fire         = host_a_valid & host_a_ready;
   assign size_err       = 32'(host_a_size) > MaxSize;

   assign device_a_opcode  = host_a_opcode;
   assign device_a_param   = host_a_param;
   assign device_a_size    = host_a_size;
   assign device_a_source  = DeviceSourceWidth'(SourceBase) + DeviceSourceWidth'(a_slot);
   assign device_a_address = host_a_address;
   assign device_a_mask    = host_a_mask;
   assign device_a_data    = host_a_data;
   assign device_a_corrupt = host_a_corrupt;

   assign d_off          = device_d_source - DeviceSourceWidth'(SourceBase);
   assign d_in_range     = {1'b0, d_off} < (DeviceSourceWidth + 1)'(NumSlots);
   assign d_slot         = d_off[SlotWidth-1:0];
   assign d_hit          = d_in_range & tbl_q[d_slot].valid;
   assign d_fire         = device_d_valid & host_d_ready;

   assign host_d_valid   = device_d_valid;
   assign device_d_ready = host_d_ready;
   assign host_d_opcode  = device_d_opcode;
   assign host_d_param   = device_d_param;
   assign host_d_size    = device_d_size;
   assign host_d_source  = d_hit ? tbl_q[d_slot].host_source : '0;
   assign host_d_sink    = device_d_sink;
   assign host_d_denied  = device_d_denied;
   assign host_d_data    = device_d_data;
   assign host_d_corrupt = device_d_corrupt;

   assign host_b_valid   = 1'b0;
   assign host_c_ready   = 1'b1;
   assign host_e_ready   = 1'b1;
   assign device_b_ready = 1'b1;
   assign device_c_valid = 1'b0;
   assign device_e_valid = 1'b0;

   assign outstanding_o  = occupancy;
   assign err_o          = err_q;
   assign unused_burst   = a_last ^ d_first;

   tl_burst_tracker #(.DataWidth(DataWidth), .MaxSize(MaxSize), .IsD(1'b0)) u_a_burst (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .fire_i   (a_fire),
      .opcode_i (host_a_opcode),
      .size_i   (host_a_size),
      .first_o  (a_first),
      .last_o   (a_last)
   );

   tl_burst_tracker #(.DataWidth(DataWidth), .MaxSize(MaxSize), .IsD(1'b1)) u_d_burst (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .fire_i   (d_fire),
      .opcode_i (device_d_opcode),
      .size_i   (device_d_size),
      .first_o  (d_first),
      .last_o   (d_last)
   );

   // Allocation picks from registered free slots, so a slot freed this cycle is never reused until the next
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumSlots; i++) tbl_q[i] <= '0;
         a_slot_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (a_fire && a_first) begin
            tbl_q[alloc_slot] <= '{valid: 1'b1, host_source: host_a_source};
            a_slot_q          <= alloc_slot;
         end
         if (d_fire && d_last && d_hit) tbl_q[d_slot].valid <= 1'b0;
         if ((a_fire && ((a_first && dup_hit) || size_err)) || (d_fire && !d_hit)) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tl_source_remapper.sv
// Directed bench for tl_source_remapper: expected device/host sources queued at stimulus time,
// popped and compared by channel monitors on each handshake.
`timescale 1ns/1ps
module tb_tl_source_remapper;
   import tl_pkg::*;

   localparam int DW = 128;
   localparam int AW = 56;
   localparam int HSW = 4;
   localparam int DSW = 5;
   localparam int SB = 8;

   logic clk = 1'b0;
   logic rst_i;
   always #5 clk = ~clk;

   logic           host_a_valid, host_a_ready, host_a_corrupt;
   logic [2:0]     host_a_opcode, host_a_param, host_a_size;
   logic [HSW-1:0] host_a_source;
   logic [AW-1:0]  host_a_address;
   logic [DW/8-1:0] host_a_mask;
   logic [DW-1:0]  host_a_data;
   logic           host_d_valid, host_d_ready, host_d_denied, host_d_corrupt;
   logic [2:0]     host_d_opcode, host_d_size;
   logic [1:0]     host_d_param;
   logic [HSW-1:0] host_d_source;
   logic [0:0]     host_d_sink;
   logic [DW-1:0]  host_d_data;
   logic           host_b_valid, host_c_ready, host_e_ready;
   logic           device_a_valid, device_a_ready, device_a_corrupt;
   logic [2:0]     device_a_opcode, device_a_param, device_a_size;
   logic [DSW-1:0] device_a_source;
   logic [AW-1:0]  device_a_address;
   logic [DW/8-1:0] device_a_mask;
   logic [DW-1:0]  device_a_data;
   logic           device_d_valid, device_d_ready, device_d_denied, device_d_corrupt;
   logic [2:0]     device_d_opcode, device_d_size;
   logic [1:0]     device_d_param;
   logic [DSW-1:0] device_d_source;
   logic [0:0]     device_d_sink;
   logic [DW-1:0]  device_d_data;
   logic           device_b_ready, device_c_valid, device_e_valid;
   logic [2:0]     outstanding_o;
   logic           err_o;

   tl_source_remapper #(
      .DataWidth(DW), .AddrWidth(AW), .SinkWidth(1), .HostSourceWidth(HSW),
      .DeviceSourceWidth(DSW), .NumSlots(4), .SourceBase(SB), .MaxSize(6)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .host_a_valid(host_a_valid), .host_a_ready(host_a_ready), .host_a_opcode(host_a_opcode),
      .host_a_param(host_a_param), .host_a_size(host_a_size), .host_a_source(host_a_source),
      .host_a_address(host_a_address), .host_a_mask(host_a_mask), .host_a_data(host_a_data),
      .host_a_corrupt(host_a_corrupt),
      .host_d_valid(host_d_valid), .host_d_ready(host_d_ready), .host_d_opcode(host_d_opcode),
      .host_d_param(host_d_param), .host_d_size(host_d_size), .host_d_source(host_d_source),
      .host_d_sink(host_d_sink), .host_d_denied(host_d_denied), .host_d_data(host_d_data),
      .host_d_corrupt(host_d_corrupt),
      .host_b_valid(host_b_valid), .host_c_ready(host_c_ready), .host_e_ready(host_e_ready),
      .device_a_valid(device_a_valid), .device_a_ready(device_a_ready), .device_a_opcode(device_a_opcode),
      .device_a_param(device_a_param), .device_a_size(device_a_size), .device_a_source(device_a_source),
      .device_a_address(device_a_address), .device_a_mask(device_a_mask), .device_a_data(device_a_data),
      .device_a_corrupt(device_a_corrupt),
      .device_d_valid(device_d_valid), .device_d_ready(device_d_ready), .device_d_opcode(device_d_opcode),
      .device_d_param(device_d_param), .device_d_size(device_d_size), .device_d_source(device_d_source),
      .device_d_sink(device_d_sink), .device_d_denied(device_d_denied), .device_d_data(device_d_data),
      .device_d_corrupt(device_d_corrupt),
      .device_b_ready(device_b_ready), .device_c_valid(device_c_valid), .device_e_valid(device_e_valid),
      .outstanding_o(outstanding_o), .err_o(err_o)
   );

   int total = 0;
   int passed = 0;
   logic [DSW-1:0] exp_a[$];
   logic [HSW-1:0] exp_d[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitors: one pop per handshake, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst_i && device_a_valid && device_a_ready) begin
         if (exp_a.size() == 0) begin
            total++;
            $display("FAIL a_unexpected: device source 0x%0h with nothing queued", device_a_source);
         end else check("a_source", device_a_source, exp_a.pop_front());
      end
      if (!rst_i && host_d_valid && host_d_ready) begin
         check("d_opcode", host_d_opcode, device_d_opcode);
         if (exp_d.size() == 0) begin
            total++;
            $display("FAIL d_unexpected: host source 0x%0h with nothing queued", host_d_source);
         end else check("d_source", host_d_source, exp_d.pop_front());
      end
   end

   task automatic a_xfer(input logic [2:0] op, input logic [2:0] size, input logic [HSW-1:0] src,
                         input logic [DSW-1:0] exp_dev, input int nbeats);
      for (int b = 0; b < nbeats; b++) begin
         int t;
         t = 0;
         exp_a.push_back(exp_dev);
         host_a_valid  = 1'b1;
         host_a_opcode = op;
         host_a_size   = size;
         host_a_source = src;
         host_a_data   = {4{32'(b)}};
         @(negedge clk);
         while (!host_a_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (!host_a_ready) begin
            total++;
            $display("FAIL a_timeout: host_a_ready got 0, expected 1 within 50 cycles");
         end
         @(posedge clk); #1;
      end
      host_a_valid = 1'b0;
   endtask

   task automatic d_xfer(input logic [2:0] op, input logic [2:0] size, input logic [DSW-1:0] dev_src,
                         input logic [HSW-1:0] exp_host, input int nbeats);
      for (int b = 0; b < nbeats; b++) begin
         exp_d.push_back(exp_host);
         device_d_valid  = 1'b1;
         device_d_opcode = op;
         device_d_size   = size;
         device_d_source = dev_src;
         @(negedge clk);
         @(posedge clk); #1;
      end
      device_d_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1;
      host_a_valid = 0; host_a_opcode = Get; host_a_param = 0; host_a_size = 4; host_a_source = 0;
      host_a_address = 56'h12_3456_7000; host_a_mask = '1; host_a_data = '0; host_a_corrupt = 0;
      host_d_ready = 0; device_a_ready = 1;
      device_d_valid = 1; device_d_opcode = AccessAck; device_d_param = 0; device_d_size = 4;
      device_d_source = 0; device_d_sink = 0; device_d_denied = 0; device_d_data = '0; device_d_corrupt = 0;

      // Reset state
      #12;
      check("rst_outstanding", outstanding_o, 0);
      check("rst_err", err_o, 0);
      check("rst_device_a_valid", device_a_valid, 0);
      check("rst_host_d_valid_hi", host_d_valid, 1);
      device_d_valid = 0; #1;
      check("rst_host_d_valid_lo", host_d_valid, 0);
      host_d_ready = 1;
      @(posedge clk); #1; rst_i = 0;
      @(posedge clk); #1;

      // Single Get
      a_xfer(Get, 4, 4'hA, SB + 0, 1);
      check("single_outstanding", outstanding_o, 1);
      d_xfer(AccessAckData, 4, SB + 0, 4'hA, 1);
      check("single_drained", outstanding_o, 0);

      // Fill to full, fifth stalls until a slot frees
      a_xfer(Get, 4, 4'h3, SB + 0, 1);
      a_xfer(Get, 4, 4'h7, SB + 1, 1);
      a_xfer(Get, 4, 4'h9, SB + 2, 1);
      a_xfer(Get, 4, 4'h1, SB + 3, 1);
      check("full_outstanding", outstanding_o, 4);
      host_a_valid = 1; host_a_opcode = Get; host_a_size = 4; host_a_source = 4'h5;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("full_host_a_ready", host_a_ready, 0);
         check("full_device_a_valid", device_a_valid, 0);
      end
      @(posedge clk); #1;
      exp_d.push_back(4'h9);
      device_d_valid = 1; device_d_opcode = AccessAckData; device_d_size = 4; device_d_source = SB + 2;
      @(negedge clk);
      check("stall_on_free_cycle", host_a_ready, 0);
      @(posedge clk); #1;
      device_d_valid = 0;
      exp_a.push_back(SB + 2);
      @(negedge clk);
      check("alloc_after_free", host_a_ready, 1);
      @(posedge clk); #1;
      host_a_valid = 0;
      check("refill_outstanding", outstanding_o, 4);
      d_xfer(AccessAck, 4, SB + 0, 4'h3, 1);
      d_xfer(AccessAck, 4, SB + 1, 4'h7, 1);
      d_xfer(AccessAck, 4, SB + 2, 4'h5, 1);
      d_xfer(AccessAck, 4, SB + 3, 4'h1, 1);
      check("fill_drained", outstanding_o, 0);

      // Four-beat Put stays on slot 0; the next Get still finds slot 1
      a_xfer(PutFullData, 6, 4'h2, SB + 0, 4);
      check("burst_outstanding", outstanding_o, 1);
      a_xfer(Get, 6, 4'h4, SB + 1, 1);
      check("burst_get_outstanding", outstanding_o, 2);
      d_xfer(AccessAck, 6, SB + 0, 4'h2, 1);
      check("ack_frees_slot0", outstanding_o, 1);
      d_xfer(AccessAckData, 6, SB + 1, 4'h4, 3);
      check("ackdata_3_beats", outstanding_o, 1);
      d_xfer(AccessAckData, 6, SB + 1, 4'h4, 1);
      check("ackdata_4_beats", outstanding_o, 0);

      // Out-of-order return and reuse of the freed slot
      a_xfer(Get, 4, 4'hB, SB + 0, 1);
      a_xfer(Get, 4, 4'hC, SB + 1, 1);
      d_xfer(AccessAckData, 4, SB + 1, 4'hC, 1);
      check("ooo_outstanding", outstanding_o, 1);
      a_xfer(Get, 4, 4'hD, SB + 1, 1);
      d_xfer(AccessAckData, 4, SB + 0, 4'hB, 1);
      d_xfer(AccessAckData, 4, SB + 1, 4'hD, 1);
      check("ooo_drained", outstanding_o, 0);
      check("no_err_yet", err_o, 0);

      // Duplicate host source and unallocated D
      a_xfer(Get, 4, 4'h6, SB + 0, 1);
      check("before_dup_err", err_o, 0);
      a_xfer(Get, 4, 4'h6, SB + 1, 1);
      check("dup_err", err_o, 1);
      repeat (3) @(posedge clk);
      #1;
      check("dup_err_sticky", err_o, 1);
      d_xfer(AccessAckData, 4, SB + 3, 4'h0, 1);
      d_xfer(AccessAckData, 4, 5'd2, 4'h0, 1);
      d_xfer(AccessAckData, 4, SB + 0, 4'h6, 1);
      d_xfer(AccessAckData, 4, SB + 1, 4'h6, 1);
      check("err_drained", outstanding_o, 0);

      // Reset after two of four Put beats
      a_xfer(PutFullData, 6, 4'h1, SB + 0, 2);
      host_a_valid = 1;
      rst_i = 1; #1;
      check("midrst_outstanding", outstanding_o, 0);
      check("midrst_err", err_o, 0);
      check("midrst_device_a_valid", device_a_valid, 0);
      host_a_valid = 0;
      @(posedge clk); #1; rst_i = 0;
      @(posedge clk); #1;
      a_xfer(Get, 4, 4'h8, SB + 0, 1);
      check("post_rst_outstanding", outstanding_o, 1);
      check("post_rst_err", err_o, 0);

      // Oversize request is forwarded and flagged
      a_xfer(Get, 7, 4'h9, SB + 1, 1);
      check("size_err", err_o, 1);

      // Responses for transactions dropped by reset hit invalid slots
      rst_i = 1; #1;
      check("rst2_err", err_o, 0);
      @(posedge clk); #1; rst_i = 0;
      d_xfer(AccessAckData, 4, SB + 0, 4'h0, 1);
      check("stale_d_err", err_o, 1);
      check("stale_outstanding", outstanding_o, 0);

      repeat (2) @(posedge clk);
      #1;
      check("exp_a_empty", exp_a.size(), 0);
      check("exp_d_empty", exp_d.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
